// File: rtl/asyn_ctrl_pkg.sv
// Shared types for the RV32I phase sequencer: opcode constants, FSM states,
// per-instruction phase-need flags and the phase-ordering helper.
package asyn_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        READ,
        EXEC,
        WB
    } state_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
        logic ex;
        logic wb;
    } need_t;

    // Next issued phase after cur; phases with no need flag are skipped.
    function automatic state_t next_phase(input state_t cur, input need_t need);
        state_t nxt;
        nxt = IDLE;
        case (cur)
            FETCH: begin
                if (need.rs1 || need.rs2) nxt = READ;
                else if (need.ex)         nxt = EXEC;
                else if (need.wb)         nxt = WB;
                else                      nxt = IDLE;
            end
            READ: begin
                if (need.ex)      nxt = EXEC;
                else if (need.wb) nxt = WB;
                else              nxt = IDLE;
            end
            EXEC: begin
                if (need.wb) nxt = WB;
                else         nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/asyn_op_decode.sv
// Combinational RV32I opcode decoder producing the phase-need flags.
module asyn_op_decode
    import asyn_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output need_t      need
);

    always_comb begin
        need = '0;
        case (opcode)
            OPC_LOAD:   need = '{rs1: 1'b1, rs2: 1'b0, ex: 1'b1, wb: 1'b1};
            OPC_STORE:  need = '{rs1: 1'b1, rs2: 1'b1, ex: 1'b1, wb: 1'b1};
            OPC_OP:     need = '{rs1: 1'b1, rs2: 1'b1, ex: 1'b1, wb: 1'b1};
            OPC_OPIMM:  need = '{rs1: 1'b1, rs2: 1'b0, ex: 1'b1, wb: 1'b1};
            OPC_BRANCH: need = '{rs1: 1'b1, rs2: 1'b1, ex: 1'b1, wb: 1'b0};
            OPC_JAL:    need = '{rs1: 1'b0, rs2: 1'b0, ex: 1'b1, wb: 1'b1};
            OPC_JALR:   need = '{rs1: 1'b1, rs2: 1'b0, ex: 1'b1, wb: 1'b1};
            OPC_LUI:    need = '{rs1: 1'b0, rs2: 1'b0, ex: 1'b0, wb: 1'b1};
            OPC_AUIPC:  need = '{rs1: 1'b0, rs2: 1'b0, ex: 1'b1, wb: 1'b1};
            default:    need = '0;
        endcase
    end

endmodule

// File: rtl/asyn_controller.sv
// Phase sequencer: issues fetch/read/execute/writeback requests for one
// instruction per start pulse, each phase held STAGE_CYCLES cycles.
module asyn_controller
    import asyn_ctrl_pkg::*;
#(
    parameter int unsigned STAGE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic [6:0] opcode,
    output logic       req1,
    output logic       req2_1,
    output logic       req2_2,
    output logic       req3,
    output logic       req4
);

    if (STAGE_CYCLES < 1 || STAGE_CYCLES > 255) begin : g_bad_param
        $error("STAGE_CYCLES must be in 1..255");
    end

    localparam logic [7:0] CNT_LAST = 8'(STAGE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] opc_q;
    need_t      need;

    // Decode from the latched opcode so input changes mid-sequence are ignored.
    asyn_op_decode u_decode (
        .opcode (opc_q),
        .need   (need)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (set) state_d = FETCH;
            end
            default: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = next_phase(state_q, need);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // Requests are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opc_q   <= '0;
            req1    <= 1'b0;
            req2_1  <= 1'b0;
            req2_2  <= 1'b0;
            req3    <= 1'b0;
            req4    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && set) opc_q <= opcode;
            req1    <= (state_d == FETCH);
            req2_1  <= (state_d == READ) && need.rs1;
            req2_2  <= (state_d == READ) && need.rs2;
            req3    <= (state_d == EXEC);
            req4    <= (state_d == WB);
        end
    end

endmodule

// File: tb/tb_asyn_controller.sv
// Directed self-checking bench: one instance with single-cycle phases and one
// with three-cycle phases, request vectors compared cycle by cycle.
module tb_asyn_controller;

    logic       clk = 1'b0;
    logic       rst1, set1, rst3, set3;
    logic [6:0] op1, op3;
    logic       a_req1, a_req2_1, a_req2_2, a_req3, a_req4;
    logic       b_req1, b_req2_1, b_req2_2, b_req3, b_req4;
    logic [4:0] out1, out3;

    int checks = 0;
    int errors = 0;

    // {req1, req2_1, req2_2, req3, req4}
    localparam logic [4:0] V_IDLE  = 5'b00000;
    localparam logic [4:0] V_FETCH = 5'b10000;
    localparam logic [4:0] V_RS1   = 5'b01000;
    localparam logic [4:0] V_RS12  = 5'b01100;
    localparam logic [4:0] V_EXEC  = 5'b00010;
    localparam logic [4:0] V_WB    = 5'b00001;

    always #5 clk = ~clk;

    asyn_controller #(.STAGE_CYCLES(1)) dut1 (
        .clk    (clk),
        .reset  (rst1),
        .set    (set1),
        .opcode (op1),
        .req1   (a_req1),
        .req2_1 (a_req2_1),
        .req2_2 (a_req2_2),
        .req3   (a_req3),
        .req4   (a_req4)
    );

    asyn_controller #(.STAGE_CYCLES(3)) dut3 (
        .clk    (clk),
        .reset  (rst3),
        .set    (set3),
        .opcode (op3),
        .req1   (b_req1),
        .req2_1 (b_req2_1),
        .req2_2 (b_req2_2),
        .req3   (b_req3),
        .req4   (b_req4)
    );

    assign out1 = {a_req1, a_req2_1, a_req2_2, a_req3, a_req4};
    assign out3 = {b_req1, b_req2_1, b_req2_2, b_req3, b_req4};

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    // Compare at the current negedge, then advance one cycle.
    task automatic step1(input string tag, input logic [4:0] exp);
        check(tag, out1, exp);
        @(negedge clk);
    endtask

    task automatic step3(input string tag, input logic [4:0] exp);
        check(tag, out3, exp);
        @(negedge clk);
    endtask

    // Present a one-edge start pulse; returns at the negedge of cycle 1.
    task automatic start1(input logic [6:0] op);
        set1 = 1'b1;
        op1  = op;
        @(negedge clk);
        set1 = 1'b0;
        op1  = 7'b1010101;
    endtask

    initial begin
        rst1 = 1'b1; set1 = 1'b0; op1 = '0;
        rst3 = 1'b1; set3 = 1'b0; op3 = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_s1", out1, V_IDLE);
        check("reset_s3", out3, V_IDLE);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        step1("idle_no_set", V_IDLE);

        // LOAD
        start1(7'b0000011);
        step1("load_c1", V_FETCH);
        step1("load_c2", V_RS1);
        step1("load_c3", V_EXEC);
        step1("load_c4", V_WB);
        step1("load_c5", V_IDLE);
        step1("load_c6", V_IDLE);

        // R-type
        start1(7'b0110011);
        step1("op_c1", V_FETCH);
        step1("op_c2", V_RS12);
        step1("op_c3", V_EXEC);
        step1("op_c4", V_WB);
        step1("op_c5", V_IDLE);

        // LUI with set pulsed during the busy cycles
        start1(7'b0110111);
        set1 = 1'b1;
        op1  = 7'b0000011;
        step1("lui_c1", V_FETCH);
        step1("lui_c2", V_WB);
        set1 = 1'b0;
        step1("lui_c3", V_IDLE);
        step1("lui_c4", V_IDLE);

        // Unknown opcode: fetch only
        start1(7'b1111111);
        step1("unk_c1", V_FETCH);
        step1("unk_c2", V_IDLE);
        step1("unk_c3", V_IDLE);

        // JAL: no reads
        start1(7'b1101111);
        step1("jal_c1", V_FETCH);
        step1("jal_c2", V_EXEC);
        step1("jal_c3", V_WB);
        step1("jal_c4", V_IDLE);

        // STORE, reset asserted while in EXEC
        start1(7'b0100011);
        step1("st_c1", V_FETCH);
        step1("st_c2", V_RS12);
        check("st_c3", out1, V_EXEC);
        rst1 = 1'b1;
        @(negedge clk);
        step1("st_rst", V_IDLE);
        rst1 = 1'b0;
        step1("st_post_rst", V_IDLE);
        start1(7'b0000011);
        step1("restart_c1", V_FETCH);
        step1("restart_c2", V_RS1);
        step1("restart_c3", V_EXEC);
        step1("restart_c4", V_WB);
        step1("restart_c5", V_IDLE);

        // set held high with LOAD: one idle cycle between sequences
        set1 = 1'b1;
        op1  = 7'b0000011;
        @(negedge clk);
        step1("hold_c1", V_FETCH);
        step1("hold_c2", V_RS1);
        step1("hold_c3", V_EXEC);
        step1("hold_c4", V_WB);
        step1("hold_c5", V_IDLE);
        check("hold_c6", out1, V_FETCH);
        set1 = 1'b0;
        @(negedge clk);
        step1("hold_c7", V_RS1);
        step1("hold_c8", V_EXEC);
        step1("hold_c9", V_WB);
        step1("hold_c10", V_IDLE);

        // BRANCH on the three-cycle instance
        set3 = 1'b1;
        op3  = 7'b1100011;
        @(negedge clk);
        set3 = 1'b0;
        op3  = 7'b0110111;
        for (int i = 0; i < 3; i++) step3("br_fetch", V_FETCH);
        for (int i = 0; i < 3; i++) step3("br_read", V_RS12);
        for (int i = 0; i < 3; i++) step3("br_exec", V_EXEC);
        step3("br_idle1", V_IDLE);
        step3("br_idle2", V_IDLE);

        // LUI on the three-cycle instance
        set3 = 1'b1;
        op3  = 7'b0110111;
        @(negedge clk);
        set3 = 1'b0;
        for (int i = 0; i < 3; i++) step3("lui3_fetch", V_FETCH);
        for (int i = 0; i < 3; i++) step3("lui3_wb", V_WB);
        step3("lui3_idle", V_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/asyn_controller.md
Name: asyn_controller

Overview:
- Phase sequencer for the SoC's RV32I datapath. It emits one-hot-per-phase request strobes: req1 for fetch, req2_1/req2_2 for source-operand reads, req3 for execute and req4 for memory/writeback.
- A start pulse (set) launches one instruction sequence. The latched 7-bit opcode decides which phases are issued and which are skipped.
- The block is implemented as a synchronous FSM. The req outputs are the handshake requests to the downstream datapath stages.

Parameters:
- STAGE_CYCLES, default 1: clock cycles each issued phase holds its request(s) high. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- set  input  1  start request; sampled only in IDLE.
- opcode  input  7  RV32I opcode field (instr[6:0]); latched when set is accepted.
- req1  output  1  fetch phase request.
- req2_1  output  1  rs1 read request.
- req2_2  output  1  rs2 read request.
- req3  output  1  execute phase request.
- req4  output  1  memory/writeback phase request.

Behaviour:
- All outputs are registered (driven from state). Reset: state=IDLE, all req*=0, stage counter=0, latched opcode=0. Reset has priority over set at every edge, including mid-sequence; all reqs are low from the next edge.
- States: IDLE, FETCH, READ, EXEC, WB.
- IDLE: when set=1 at an edge, latch opcode, go to FETCH. Otherwise stay.
- FETCH is always issued: req1=1.
- READ is issued if need_rs1 or need_rs2: req2_1=need_rs1, req2_2=need_rs2. Both may be high together.
- EXEC is issued if need_ex: req3=1.
- WB is issued if need_wb: req4=1.
- Each issued phase lasts exactly STAGE_CYCLES cycles. Phases whose need flags are all 0 are skipped with zero cycles. The transition goes directly to the next issued phase, or to IDLE after the last one.
- At most one phase's requests are high in any cycle. All req*=0 in IDLE.
- Decode table (need_rs1, need_rs2, need_ex, need_wb):
  - LOAD 0000011 = 1,0,1,1
  - STORE 0100011 = 1,1,1,1
  - OP 0110011 = 1,1,1,1
  - OP-IMM 0010011 = 1,0,1,1
  - BRANCH 1100011 = 1,1,1,0
  - JAL 1101111 = 0,0,1,1
  - JALR 1100111 = 1,0,1,1
  - LUI 0110111 = 0,0,0,1
  - AUIPC 0010111 = 0,0,1,1
  - Any other opcode = 0,0,0,0, i.e. FETCH only, then IDLE.
- set is ignored while not in IDLE; no queuing. A set held high continuously restarts a new sequence on the first edge back in IDLE, i.e. one idle cycle between sequences.
- Changes on opcode after acceptance have no effect on the running sequence.
- The stage counter counts 0..STAGE_CYCLES-1 and resets on every phase transition.

Decomposition:
- Package asyn_ctrl_pkg holds:
  - the opcode localparams (OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - typedef enum state_t {IDLE, FETCH, READ, EXEC, WB};
  - a packed struct need_t {rs1, rs2, ex, wb}.
- Sub-module asyn_op_decode: a combinational opcode-to-need_t decoder.
- The top level holds the FSM, the stage counter and the output registers.

Test Plan:
- Reset then LOAD, STAGE_CYCLES=1: assert reset 2 cycles, then set=1 with opcode=0000011 for one edge.
  - Required: req1 in cycle 1, req2_1 alone in cycle 2, req3 in cycle 3, req4 in cycle 4, all 0 from cycle 5. req2_2 is never asserted.
- R-type 0110011: req1 in cycle 1, then req2_1 and req2_2 both high in cycle 2, then req3, then req4, then idle.
- BRANCH 1100011 with STAGE_CYCLES=3:
  - req1 for 3 cycles, then req2_1+req2_2 for 3 cycles, then req3 for 3 cycles.
  - req4 is never high. Idle after 9 cycles.
- LUI 0110111: req1 1 cycle then req4 1 cycle. Unknown opcode 1111111: req1 1 cycle then idle. set pulses during busy cycles are ignored.
- Reset mid-sequence: start STORE 0100011 and assert reset while in EXEC.
  - All req* are 0 on the next edge; state is IDLE.
  - A new set after reset deasserts starts a fresh FETCH.
- set held at 1 with LOAD: sequences repeat with exactly one all-zero IDLE cycle between WB and the next FETCH.
